// File: rtl/clk_div_n_duty50.sv
// ============================================================================
// Module   : clk_div_n_duty50
// Brief    : Programmable 50%-duty integer clock divider (N = 2..2^WIDTH-1)
//            with period-boundary ratio switching and a per-period strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_n_duty50 #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             pulse_out,
    output logic [WIDTH-1:0] div_cur,
    output logic             load_ack
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend_vld;
    logic             r_pos_q;
    logic             r_neg_q;
    logic             r_pulse;
    logic             r_load_ack;

    logic             w_wrap;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_cnt_inc;

    always_comb begin
        w_wrap    = en && (r_cnt == (r_div_cur - C_ONE));
        w_load_ok = div_load && (div_in >= C_MIN_DIV);
        w_div_nxt = (w_wrap && r_pend_vld) ? r_pend_val : r_div_cur;
        w_half    = w_div_nxt >> 1;
        w_cnt_inc = r_cnt + C_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= C_DEFAULT_DIV - C_ONE;
            r_div_cur  <= C_DEFAULT_DIV;
            r_pend_val <= C_DEFAULT_DIV;
            r_pend_vld <= 1'b0;
            r_pos_q    <= 1'b0;
            r_pulse    <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            // A new request on a wrap edge wins: the old value is consumed
            // this edge and the new one stays pending for the next wrap.
            if (w_load_ok) begin
                r_pend_val <= div_in;
                r_pend_vld <= 1'b1;
            end else if (w_wrap && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            if (en) begin
                if (w_wrap) begin
                    r_cnt      <= '0;
                    r_pos_q    <= 1'b1;
                    r_pulse    <= 1'b1;
                    r_div_cur  <= w_div_nxt;
                    r_load_ack <= r_pend_vld;
                end else begin
                    r_cnt      <= w_cnt_inc;
                    r_pos_q    <= (w_cnt_inc < w_half);
                    r_pulse    <= 1'b0;
                    r_load_ack <= 1'b0;
                end
            end else begin
                r_pulse    <= 1'b0;
                r_load_ack <= 1'b0;
            end
        end
    end

    // Half-cycle extension stage for odd ratios.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= r_pos_q;
        end
    end

    always_comb begin
        clk_out   = r_div_cur[0] ? (r_pos_q | r_neg_q) : r_pos_q;
        pulse_out = r_pulse;
        load_ack  = r_load_ack;
        div_cur   = r_div_cur;
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_n_duty50.sv
// ============================================================================
// Module   : tb_clk_div_n_duty50
// Brief    : Scoreboard bench for clk_div_n_duty50 using directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_n_duty50;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       clk_out;
    logic       pulse_out;
    logic [7:0] div_cur;
    logic       load_ack;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       clk_p;
        logic       clk_n;
        logic       pulse;
        logic       ack;
        logic [7:0] div;
    } exp_t;

    exp_t sb[$];

    clk_div_n_duty50 #(.WIDTH(8), .DEFAULT_DIV(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .pulse_out (pulse_out),
        .div_cur   (div_cur),
        .load_ack  (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per clk cycle, sampled after each edge.
    initial begin
        logic       s_clk_p, s_pulse, s_ack, s_clk_n;
        logic [7:0] s_div;
        exp_t       e;
        forever begin
            @(posedge clk); #1;
            s_clk_p = clk_out;
            s_pulse = pulse_out;
            s_ack   = load_ack;
            s_div   = div_cur;
            @(negedge clk); #1;
            s_clk_n = clk_out;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("clk_out_after_posedge", {7'd0, s_clk_p}, {7'd0, e.clk_p});
                chk("clk_out_after_negedge", {7'd0, s_clk_n}, {7'd0, e.clk_n});
                chk("pulse_out", {7'd0, s_pulse}, {7'd0, e.pulse});
                chk("load_ack", {7'd0, s_ack}, {7'd0, e.ack});
                chk("div_cur", s_div, e.div);
            end
        end
    end

    // One enabled cycle at phase k of an N-period: high for H cycles, plus
    // an extra half cycle (until the negedge) when N is odd.
    task automatic cyc(input logic e, input logic ld, input logic [7:0] din,
                       input int k, input int n, input logic ack);
        exp_t x;
        int   h;
        h        = n / 2;
        en       = e;
        div_load = ld;
        div_in   = din;
        x.clk_p  = (k < h) || ((n % 2 == 1) && (k == h));
        x.clk_n  = (k < h);
        x.pulse  = (k == 0);
        x.ack    = ack;
        x.div    = 8'(n);
        sb.push_back(x);
        @(negedge clk); #2;
    endtask

    task automatic raw(input logic r, input logic e, input logic cp,
                       input logic cn, input logic [7:0] d);
        exp_t x;
        rst      = r;
        en       = e;
        div_load = 1'b0;
        div_in   = 8'd0;
        x.clk_p  = cp;
        x.clk_n  = cn;
        x.pulse  = 1'b0;
        x.ack    = 1'b0;
        x.div    = d;
        sb.push_back(x);
        @(negedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t x;
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = 8'd0;
        @(negedge clk); #2;

        // Reset state
        repeat (3) raw(1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        rst = 1'b0;

        // Default ratio 9, five full periods
        for (int i = 0; i < 45; i++) cyc(1'b1, 1'b0, 8'd0, i % 9, 9, 1'b0);

        // Load 4 with cnt=2, then load 9 back
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'd0, k, 9, 1'b0);
        cyc(1'b1, 1'b1, 8'd4, 3, 9, 1'b0);
        for (int k = 4; k < 9; k++) cyc(1'b1, 1'b0, 8'd0, k, 9, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'd0, i % 4, 4, i == 0);
        cyc(1'b1, 1'b0, 8'd0, 0, 4, 1'b0);
        cyc(1'b1, 1'b1, 8'd9, 1, 4, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 2, 4, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 3, 4, 1'b0);
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 8'd0, i % 9, 9, i == 0);

        // Two loads in one period; last wins with a single ack
        cyc(1'b1, 1'b0, 8'd0, 0, 9, 1'b0);
        cyc(1'b1, 1'b1, 8'd5, 1, 9, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 2, 9, 1'b0);
        cyc(1'b1, 1'b1, 8'd6, 3, 9, 1'b0);
        for (int k = 4; k < 9; k++) cyc(1'b1, 1'b0, 8'd0, k, 9, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'd0, i, 6, i == 0);

        // Illegal ratios 1 and 0 are ignored
        cyc(1'b1, 1'b0, 8'd0, 0, 6, 1'b0);
        cyc(1'b1, 1'b1, 8'd1, 1, 6, 1'b0);
        cyc(1'b1, 1'b1, 8'd0, 2, 6, 1'b0);
        for (int k = 3; k < 6; k++) cyc(1'b1, 1'b0, 8'd0, k, 6, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'd0, i % 6, 6, 1'b0);

        // Enable low for 5 cycles in the high phase stretches the period
        cyc(1'b1, 1'b0, 8'd0, 0, 6, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 1, 6, 1'b0);
        repeat (5) raw(1'b0, 1'b0, 1'b1, 1'b1, 8'd6);
        for (int k = 2; k < 6; k++) cyc(1'b1, 1'b0, 8'd0, k, 6, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'd0, i, 6, 1'b0);

        // Async reset in the high phase with a load pending
        cyc(1'b1, 1'b0, 8'd0, 0, 6, 1'b0);
        en       = 1'b1;
        div_load = 1'b1;
        div_in   = 8'd4;
        x.clk_p  = 1'b1;
        x.clk_n  = 1'b0;
        x.pulse  = 1'b0;
        x.ack    = 1'b0;
        x.div    = 8'd6;
        sb.push_back(x);
        @(posedge clk); #3;
        rst = 1'b1;
        @(negedge clk); #2;
        repeat (2) raw(1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 8'd0, i % 9, 9, 1'b0);

        // N=2 then N=3
        cyc(1'b1, 1'b0, 8'd0, 0, 9, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 1, 9, 1'b0);
        cyc(1'b1, 1'b1, 8'd2, 2, 9, 1'b0);
        for (int k = 3; k < 9; k++) cyc(1'b1, 1'b0, 8'd0, k, 9, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'd0, i % 2, 2, i == 0);
        cyc(1'b1, 1'b0, 8'd0, 0, 2, 1'b0);
        cyc(1'b1, 1'b1, 8'd3, 1, 2, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'd0, i % 3, 3, i == 0);

        en       = 1'b0;
        div_load = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
